// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - BHT counter type, saturating update and SB-immediate extension
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_ctr_t;

  localparam bht_ctr_t BHT_CTR_RESET = WEAK_NT;

  function automatic bht_ctr_t sat_update(bht_ctr_t ctr, logic taken);
    if (taken) begin
      return (ctr == STRONG_T) ? STRONG_T : bht_ctr_t'(ctr + 2'd1);
    end
    return (ctr == STRONG_NT) ? STRONG_NT : bht_ctr_t'(ctr - 2'd1);
  endfunction

  function automatic logic [31:0] sext_sb(logic [12:0] imm);
    return {{19{imm[12]}}, imm};
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// rtl/bht_predictor_if.sv - fetch-side predictor access and execute-side update bundle
interface bht_predictor_if;

  logic [31:0] current_pc;
  logic        is_branch;
  logic        is_rv32c;
  logic [12:0] imm_sb;

  logic        update_predictor;
  logic [31:0] pc_to_update;
  logic        branch_result;
  logic        prediction;
  logic [31:0] update_addr;
  logic        direction;

  logic        predict_taken;
  logic [31:0] target_addr;

  modport fetch (
    output current_pc, is_branch, is_rv32c, imm_sb,
    output update_predictor, pc_to_update, branch_result,
    output prediction, update_addr, direction,
    input  predict_taken, target_addr
  );

  modport predictor (
    input  current_pc, is_branch, is_rv32c, imm_sb,
    input  update_predictor, pc_to_update, branch_result,
    input  prediction, update_addr, direction,
    output predict_taken, target_addr
  );

endinterface

// File: rtl/bht_array.sv
// rtl/bht_array.sv - 2-bit counter storage: two async read ports, one sync write port
module bht_array
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 7
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [IDX_BITS-1:0] pidx,
  output bht_ctr_t            pdata,
  input  logic [IDX_BITS-1:0] uidx,
  output bht_ctr_t            udata,
  input  logic                we,
  input  logic [IDX_BITS-1:0] widx,
  input  bht_ctr_t            wdata
);

  localparam int ENTRIES = 1 << IDX_BITS;

  bht_ctr_t mem [ENTRIES];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= BHT_CTR_RESET;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign pdata = mem[pidx];
  assign udata = mem[uidx];

endmodule

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - BHT direction/target predictor with forwarding update stage
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 7,
  parameter int GHR_BITS = 7
) (
  input  logic                 CLK,
  input  logic                 nRST,
  bht_predictor_if.predictor   bp
);

  logic [IDX_BITS-1:0] hist;
  logic [IDX_BITS-1:0] pidx;
  logic [IDX_BITS-1:0] uidx;

`ifdef BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ghr <= '0;
    end else if (bp.update_predictor) begin
      ghr <= (ghr << 1) | GHR_BITS'(bp.branch_result);
    end
  end

  assign hist = IDX_BITS'(ghr);
`else
  logic [GHR_BITS-1:0] unused_ghr_shape;
  assign unused_ghr_shape = '0;
  assign hist = '0;
`endif

  assign pidx = bp.current_pc[IDX_BITS:1] ^ hist;
  assign uidx = bp.pc_to_update[IDX_BITS:1] ^ hist;

  logic                stg_valid;
  logic [IDX_BITS-1:0] stg_idx;
  bht_ctr_t            stg_ctr;

  bht_ctr_t arr_pdata;
  bht_ctr_t arr_udata;

  bht_array #(
    .IDX_BITS (IDX_BITS)
  ) u_array (
    .CLK   (CLK),
    .nRST  (nRST),
    .pidx  (pidx),
    .pdata (arr_pdata),
    .uidx  (uidx),
    .udata (arr_udata),
    .we    (stg_valid),
    .widx  (stg_idx),
    .wdata (stg_ctr)
  );

  // The stage holds the newest value for its index until the array write lands.
  bht_ctr_t p_ctr;
  bht_ctr_t u_old;

  assign p_ctr = (stg_valid && (stg_idx == pidx)) ? stg_ctr : arr_pdata;
  assign u_old = (stg_valid && (stg_idx == uidx)) ? stg_ctr : arr_udata;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stg_valid <= 1'b0;
      stg_idx   <= '0;
      stg_ctr   <= BHT_CTR_RESET;
    end else if (bp.update_predictor) begin
      stg_valid <= 1'b1;
      stg_idx   <= uidx;
      stg_ctr   <= sat_update(u_old, bp.branch_result);
    end else begin
      stg_valid <= 1'b0;
    end
  end

  assign bp.predict_taken = bp.is_branch & p_ctr[1];
  assign bp.target_addr   = bp.current_pc + sext_sb(bp.imm_sb);

  logic unused_inputs;
  assign unused_inputs = ^{bp.is_rv32c, bp.prediction, bp.update_addr, bp.direction,
                           bp.pc_to_update};

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - directed self-checking bench for bht_predictor
module tb_bht_predictor;

  logic CLK;
  logic nRST;
  int   compared;
  int   mismatched;

  bht_predictor_if bp_if ();

  bht_predictor #(
    .IDX_BITS (7),
    .GHR_BITS (7)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bp   (bp_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_pt(input string name, input logic exp);
    compared++;
    if (bp_if.predict_taken !== exp) begin
      mismatched++;
      $display("FAIL %s: predict_taken=%b expected %b", name, bp_if.predict_taken, exp);
    end
  endtask

  task automatic set_predict(input logic [31:0] pc, input logic br);
    bp_if.current_pc = pc;
    bp_if.is_branch  = br;
  endtask

  task automatic set_update(input logic en, input logic [31:0] pc, input logic taken);
    bp_if.update_predictor = en;
    bp_if.pc_to_update     = pc;
    bp_if.branch_result    = taken;
  endtask

  task automatic do_reset();
    set_update(1'b0, 32'h0, 1'b0);
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    set_predict(32'h100, 1'b1);
    bp_if.imm_sb = 13'h010;
    settle();
    check_pt("reset_pt", 1'b0);
    compared++;
    if (bp_if.target_addr !== 32'h110) begin
      mismatched++;
      $display("FAIL reset_target: target_addr=%h expected %h", bp_if.target_addr, 32'h110);
    end
    next_cycle();
    nRST = 1'b1;
    settle();
    check_pt("reset_release_pt", 1'b0);
  endtask

  task automatic test_saturate();
    logic exp_seq [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic upd_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic en_seq  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_predict(32'h100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      set_update(en_seq[i], 32'h100, upd_seq[i]);
      settle();
      check_pt($sformatf("sat_step%0d", i), exp_seq[i]);
      next_cycle();
    end
    set_update(1'b0, 32'h0, 1'b0);
    next_cycle();
    check_pt("sat_array_final", 1'b0);
  endtask

  task automatic test_forwarding();
    do_reset();
    set_predict(32'h100, 1'b1);
    set_update(1'b1, 32'h100, 1'b1);
    settle();
    check_pt("fwd_same_cycle_old", 1'b0);
    next_cycle();
    set_update(1'b0, 32'h0, 1'b0);
    settle();
    check_pt("fwd_n_plus_1", 1'b1);
    set_predict(32'h104, 1'b1);
    settle();
    check_pt("fwd_other_index", 1'b0);
    set_predict(32'h100, 1'b1);
    next_cycle();
    check_pt("fwd_array_n_plus_2", 1'b1);
  endtask

  task automatic test_target();
    logic [31:0] pcs  [3] = '{32'h200, 32'hFFFF_FFFC, 32'h1000};
    logic [12:0] imms [3] = '{13'h1FFC, 13'h0008, 13'h1000};
    logic [31:0] exps [3] = '{32'h1FC, 32'h4, 32'h0};
    for (int i = 0; i < 3; i++) begin
      set_predict(pcs[i], 1'b0);
      bp_if.imm_sb = imms[i];
      settle();
      compared++;
      if (bp_if.target_addr !== exps[i]) begin
        mismatched++;
        $display("FAIL target%0d: target_addr=%h expected %h", i, bp_if.target_addr, exps[i]);
      end
    end
  endtask

  task automatic test_is_branch();
    do_reset();
    set_update(1'b1, 32'h100, 1'b1);
    next_cycle();
    set_update(1'b0, 32'h0, 1'b0);
    next_cycle();
    set_predict(32'h100, 1'b0);
    settle();
    check_pt("not_branch", 1'b0);
    set_predict(32'h100, 1'b1);
    settle();
    check_pt("is_branch", 1'b1);
  endtask

  task automatic test_reset_mid_update();
    do_reset();
    set_predict(32'h100, 1'b1);
    set_update(1'b1, 32'h100, 1'b1);
    next_cycle();
    next_cycle();
    settle();
    check_pt("pre_reset_staged", 1'b1);
    nRST = 1'b0;
    settle();
    check_pt("during_reset", 1'b0);
    set_update(1'b0, 32'h0, 1'b0);
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    check_pt("after_reset", 1'b0);
  endtask

  task automatic test_different_index();
    do_reset();
    set_update(1'b1, 32'h100, 1'b1);
    next_cycle();
    set_update(1'b1, 32'h104, 1'b1);
    next_cycle();
    set_update(1'b0, 32'h0, 1'b0);
    next_cycle();
    set_predict(32'h100, 1'b1);
    settle();
    check_pt("diff_idx_a", 1'b1);
    set_predict(32'h104, 1'b1);
    settle();
    check_pt("diff_idx_b", 1'b1);
    set_predict(32'h102, 1'b1);
    settle();
    check_pt("diff_idx_untouched", 1'b0);
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    do_reset();
    set_update(1'b1, 32'h100, 1'b1);
    next_cycle();
    set_update(1'b0, 32'h0, 1'b0);
    next_cycle();
    set_predict(32'h102, 1'b1);
    settle();
    check_pt("gshare_hist_index", 1'b1);
    set_predict(32'h100, 1'b1);
    settle();
    check_pt("gshare_no_alias", 1'b0);
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    bp_if.current_pc = 32'h0;
    bp_if.is_branch  = 1'b0;
    bp_if.is_rv32c   = 1'b0;
    bp_if.imm_sb     = 13'h0;
    bp_if.prediction  = 1'b0;
    bp_if.update_addr = 32'h0;
    bp_if.direction   = 1'b0;
    set_update(1'b0, 32'h0, 1'b0);
    nRST = 1'b1;
    #1;
    test_reset();
    test_target();
`ifdef BHT_GSHARE_EN
    test_gshare();
`else
    test_saturate();
    test_forwarding();
    test_is_branch();
    test_reset_mid_update();
    test_different_index();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
